// File: rtl/tdm_demux.sv
// Receive end of a TDM lane-select link: reassembles a serial slot stream into a
// LANES-bit word, using a frame-sync marker to locate slot 0.
module tdm_demux #(
  parameter int LANES = 4,
  parameter int SEL_W = $clog2(LANES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             sync,
  output logic [LANES-1:0] out_word,
  output logic             out_valid,
  output logic [SEL_W-1:0] select,
  output logic             sync_err
);

  typedef enum logic {HUNT, COLLECT} state_t;

  localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(LANES - 1);
  localparam logic [SEL_W-1:0] SLOT_ONE  = SEL_W'(1);

  state_t           state_reg;
  logic [LANES-1:0] staging_reg;
  logic [LANES-1:0] staging_next;
  logic             realign;
  logic             stage_we;
  logic [SEL_W-1:0] stage_idx;

  // A sync seen mid-frame restarts the frame at slot 0 with this beat's bit.
  assign realign   = in_valid && sync && (state_reg == COLLECT) && (select != '0);
  assign stage_we  = in_valid && ((state_reg == COLLECT) || sync);
  assign stage_idx = ((state_reg == HUNT) || realign) ? '0 : select;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_stage
      assign staging_next[gi] = (stage_we && (stage_idx == SEL_W'(gi))) ? in_bit
                                                                        : staging_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= HUNT;
      select      <= '0;
      staging_reg <= '0;
      out_word    <= '0;
      out_valid   <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      out_valid   <= 1'b0;
      sync_err    <= 1'b0;
      staging_reg <= staging_next;
      if (in_valid) begin
        case (state_reg)
          HUNT: begin
            if (sync) begin
              select    <= SLOT_ONE;
              state_reg <= COLLECT;
            end
          end
          COLLECT: begin
            if (realign) begin
              select   <= SLOT_ONE;
              sync_err <= 1'b1;
            end else if (select == LAST_SLOT) begin
              // The last slot bit goes straight to the output, bypassing staging.
              out_word  <= {in_bit, staging_reg[LANES-2:0]};
              out_valid <= 1'b1;
              select    <= '0;
            end else begin
              select <= select + SLOT_ONE;
            end
          end
          default: state_reg <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux.sv
// Directed bench for tdm_demux: framing, hunting, gaps, realign, back-to-back
// frames and asynchronous reset mid-frame.
module tb_tdm_demux;

  localparam int LANES = 4;
  localparam int SEL_W = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_bit = 1'b0;
  logic             sync = 1'b0;
  logic [LANES-1:0] out_word;
  logic             out_valid;
  logic [SEL_W-1:0] select;
  logic             sync_err;

  int errors = 0;
  int checks = 0;

  tdm_demux #(.LANES(LANES), .SEL_W(SEL_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_bit   (in_bit),
    .sync     (sync),
    .out_word (out_word),
    .out_valid(out_valid),
    .select   (select),
    .sync_err (sync_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs at a falling edge; return at the next falling edge,
  // after the rising edge that sampled them.
  task automatic step(input logic v, input logic b, input logic s);
    in_valid = v;
    in_bit   = b;
    sync     = s;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset state
    #3 rst_n = 1'b0;
    #4;
    chk("rst_word", 32'(out_word), 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_select", 32'(select), 32'h0);
    chk("rst_err", 32'(sync_err), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: basic frame 1,0,0,1
    step(1, 1, 1); chk("t1_sel1", 32'(select), 32'd1);
    step(1, 0, 0); chk("t1_sel2", 32'(select), 32'd2);
    step(1, 0, 0); chk("t1_sel3", 32'(select), 32'd3);
    chk("t1_novalid", 32'(out_valid), 32'h0);
    step(1, 1, 0);
    chk("t1_valid", 32'(out_valid), 32'h1);
    chk("t1_word", 32'(out_word), 32'h9);
    chk("t1_sel0", 32'(select), 32'd0);
    step(0, 0, 0);
    chk("t1_pulse", 32'(out_valid), 32'h0);
    chk("t1_hold", 32'(out_word), 32'h9);
    $display("txn t1 frame 1001 word=%b", out_word);

    // 2: unsynced beats are discarded while hunting
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0);
      chk("t2_hunt_sel", 32'(select), 32'd0);
      chk("t2_hunt_valid", 32'(out_valid), 32'h0);
    end
    step(1, 0, 1); step(1, 1, 0); step(1, 1, 0); step(1, 0, 0);
    chk("t2_valid", 32'(out_valid), 32'h1);
    chk("t2_word", 32'(out_word), 32'h6);
    $display("txn t2 frame 0110 word=%b", out_word);

    // 3: idle cycle between every beat
    step(1, 1, 1); step(0, 0, 0); chk("t3_idle1", 32'(select), 32'd1);
    step(1, 0, 0); step(0, 1, 1); chk("t3_idle2", 32'(select), 32'd2);
    step(1, 0, 0); step(0, 1, 0); chk("t3_idle3", 32'(select), 32'd3);
    chk("t3_novalid", 32'(out_valid), 32'h0);
    step(1, 1, 0);
    chk("t3_valid", 32'(out_valid), 32'h1);
    chk("t3_word", 32'(out_word), 32'h9);
    step(0, 0, 0);
    chk("t3_pulse", 32'(out_valid), 32'h0);
    $display("txn t3 gapped frame 1001 word=%b", out_word);

    // 4: sync arriving at select=2 realigns the frame
    step(1, 0, 1); step(1, 0, 0);
    chk("t4_sel2", 32'(select), 32'd2);
    step(1, 1, 1);
    chk("t4_err", 32'(sync_err), 32'h1);
    chk("t4_sel1", 32'(select), 32'd1);
    chk("t4_word_kept", 32'(out_word), 32'h9);
    chk("t4_novalid", 32'(out_valid), 32'h0);
    step(1, 1, 0);
    chk("t4_err_pulse", 32'(sync_err), 32'h0);
    step(1, 1, 0); step(1, 1, 0);
    chk("t4_valid", 32'(out_valid), 32'h1);
    chk("t4_word", 32'(out_word), 32'hF);
    $display("txn t4 realigned frame word=%b", out_word);

    // 5: back-to-back frames 1001 then 0110
    step(1, 1, 1); step(1, 0, 0); step(1, 0, 0); step(1, 1, 0);
    chk("t5_valid_a", 32'(out_valid), 32'h1);
    chk("t5_word_a", 32'(out_word), 32'h9);
    step(1, 0, 1);
    chk("t5_gap", 32'(out_valid), 32'h0);
    chk("t5_sel1", 32'(select), 32'd1);
    chk("t5_noerr", 32'(sync_err), 32'h0);
    step(1, 1, 0); step(1, 1, 0);
    chk("t5_mid", 32'(out_valid), 32'h0);
    step(1, 0, 0);
    chk("t5_valid_b", 32'(out_valid), 32'h1);
    chk("t5_word_b", 32'(out_word), 32'h6);
    $display("txn t5 back-to-back words 1001,%b", out_word);

    // 6: asynchronous reset in the middle of the slot-2 cycle
    step(1, 1, 1); step(1, 0, 0);
    chk("t6_sel2", 32'(select), 32'd2);
    in_valid = 1'b1; in_bit = 1'b1; sync = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_word", 32'(out_word), 32'h0);
    chk("t6_async_sel", 32'(select), 32'd0);
    chk("t6_async_valid", 32'(out_valid), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 0);
      chk("t6_hunt_sel", 32'(select), 32'd0);
      chk("t6_hunt_valid", 32'(out_valid), 32'h0);
    end
    chk("t6_word", 32'(out_word), 32'h0);
    step(1, 1, 1);
    chk("t6_resync", 32'(select), 32'd1);
    $display("txn t6 reset mid-frame select=%0d", select);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
